// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-lite encodings, the SRAM slave phase-state type and
// the byte-lane strobe helper used when committing writes into the array.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slave_state_e;

    // Little-endian lane enables for a legal (aligned) access; illegal sizes
    // enable nothing.
    function automatic logic [3:0] byte_strobe(input logic [2:0] size,
                                               input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (size)
            HSIZE_BYTE: strb = 4'b0001 << addr_lo;
            HSIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: strb = 4'b1111;
            default:    strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/sram_word_array.sv
// sram_word_array: DEPTH_WORDS x 32-bit storage with per-byte write enables
// and an asynchronous read port sharing the same word index.
//   hclk   in   clock
//   we     in   byte write enables, lane i = wdata[8i+7:8i]
//   addr   in   word index (read and write)
//   wdata  in   write data
//   rdata  out  word at addr, combinational
module sram_word_array #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           hclk,
    input  logic [3:0]                     we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge hclk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-lite responder fronting a word-organised SRAM.
// Byte/half/word accesses, WAIT_STATES hready-low cycles per OKAY data phase,
// two-cycle ERROR response for unaligned or oversized accesses.
//   hclk, hreset         clock, synchronous active-high reset
//   hsel, haddr, htrans  address phase from the bridge
//   hwrite, hsize        address phase control
//   hwdata               write data, valid in the data phase
//   hready_in            bus-wide ready
//   hrdata, hready, hresp  data phase response
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no data phase pending; ready, OKAY
// WAIT    | OKAY data phase stalled; counter counts down to 1
// DATA    | OKAY data phase completing; write commits at its closing edge
// ERR1    | first ERROR cycle, hready low
// ERR2    | second ERROR cycle, hready high
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready_in,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        hresp
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    slave_state_e  state_q, state_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [2:0]    size_q, size_d;
    logic          write_q, write_d;

    logic          accept;
    logic          addr_err;
    logic [3:0]    mem_we;
    logic [31:0]   mem_rdata;
    logic          unused_bits;

    // Upper address bits alias; htrans[0] only distinguishes SEQ from NONSEQ.
    assign unused_bits = ^{haddr[31:AW+2], htrans[0]};

    assign accept = hsel & htrans[1] & hready_in;

    always_comb begin
        addr_err = 1'b0;
        if (hsize > HSIZE_WORD) begin
            addr_err = 1'b1;
        end else if (hsize == HSIZE_HALF && haddr[0]) begin
            addr_err = 1'b1;
        end else if (hsize == HSIZE_WORD && haddr[1:0] != 2'b00) begin
            addr_err = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            ST_WAIT: begin
                wcnt_d = wcnt_q - 4'd1;
                if (wcnt_q == 4'd1) begin
                    state_d = ST_DATA;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                // IDLE, DATA and ERR2 drive hready high, so the next address
                // phase can be taken in the same cycle with no bubble.
                state_d = ST_IDLE;
                if (accept) begin
                    addr_d  = haddr[AW+1:0];
                    size_d  = hsize;
                    write_d = hwrite;
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = WAIT_CNT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 4'd0;
            addr_q  <= '0;
            size_q  <= 3'd0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

    // A reset landing on the closing edge of a write drops that write.
    assign mem_we = (state_q == ST_DATA && write_q && !hreset)
                    ? byte_strobe(size_q, addr_q[1:0]) : 4'b0000;

    sram_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .hclk  (hclk),
        .we    (mem_we),
        .addr  (addr_q[AW+1:2]),
        .wdata (hwdata),
        .rdata (mem_rdata)
    );

    assign hready = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
    assign hresp  = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign hrdata = (state_q == ST_DATA && !write_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;

    localparam int DEPTH = 64;
    localparam int NDUT  = 3;

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct packed {
        logic        rdy;
        logic        rsp;
        logic [31:0] rd;
    } obs_t;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel_b;
    logic [31:0] haddr_b;
    logic [1:0]  htrans_b;
    logic        hwrite_b;
    logic [2:0]  hsize_b;
    logic [31:0] hwdata_b;

    logic        hready_o [NDUT];
    logic        hresp_o  [NDUT];
    logic [31:0] hrdata_o [NDUT];

    int          cur = 0;
    logic        hready_c, hresp_c;
    logic [31:0] hrdata_c;

    int vectors     = 0;
    int miscompares = 0;

    int          ws_of [NDUT] = '{0, 2, 3};
    logic [31:0] mem_m [NDUT][DEPTH];

    xfer_t       seq_q [$];
    obs_t        obs_q [$];
    obs_t        exp_q [$];
    logic [31:0] rd_q  [$];

    always #5 hclk = ~hclk;

    ahb_sram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel_b && (cur == 0)), .haddr(haddr_b),
        .htrans(htrans_b), .hwrite(hwrite_b), .hsize(hsize_b), .hwdata(hwdata_b),
        .hready_in(hready_o[0]), .hrdata(hrdata_o[0]), .hready(hready_o[0]), .hresp(hresp_o[0]));

    ahb_sram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) u_ws2 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel_b && (cur == 1)), .haddr(haddr_b),
        .htrans(htrans_b), .hwrite(hwrite_b), .hsize(hsize_b), .hwdata(hwdata_b),
        .hready_in(hready_o[1]), .hrdata(hrdata_o[1]), .hready(hready_o[1]), .hresp(hresp_o[1]));

    ahb_sram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_ws3 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel_b && (cur == 2)), .haddr(haddr_b),
        .htrans(htrans_b), .hwrite(hwrite_b), .hsize(hsize_b), .hwdata(hwdata_b),
        .hready_in(hready_o[2]), .hrdata(hrdata_o[2]), .hready(hready_o[2]), .hresp(hresp_o[2]));

    assign hready_c = hready_o[cur];
    assign hresp_c  = hresp_o[cur];
    assign hrdata_c = hrdata_o[cur];

    // ---------------- reference model ----------------
    function automatic xfer_t mk(logic sel, logic [1:0] tr, logic wr, logic [2:0] sz,
                                 logic [31:0] a, logic [31:0] d);
        xfer_t x;
        x.sel = sel; x.trans = tr; x.wr = wr; x.size = sz; x.addr = a; x.data = d;
        return x;
    endfunction

    function automatic logic is_err(xfer_t x);
        longint nb;
        nb = longint'(1) << x.size;
        return (x.size > 3'd2) || ((longint'(x.addr) % nb) != 0);
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'((longint'(a) / 4) % DEPTH);
    endfunction

    // A byte lane is written when its byte address falls inside [addr, addr+size).
    task automatic model_write(xfer_t x);
        longint nb, base, ba;
        int     w;
        nb   = longint'(1) << x.size;
        base = longint'(x.addr) - (longint'(x.addr) % 4);
        w    = widx(x.addr);
        for (int b = 0; b < 4; b++) begin
            ba = base + b;
            if (ba >= longint'(x.addr) && ba < longint'(x.addr) + nb) begin
                mem_m[cur][w][8*b +: 8] = x.data[8*b +: 8];
            end
        end
    endtask

    task automatic drive_idle();
        hsel_b = 1'b0; htrans_b = 2'b00; hwrite_b = 1'b0;
        hsize_b = 3'd0; haddr_b = 32'h0; hwdata_b = 32'h0;
    endtask

    // Pipelined master: drains seq_q against the DUT selected by cur, logging
    // observed and model-expected response for every cycle.
    task automatic run_seq();
        xfer_t ap, dp;
        logic  ap_v, dp_v, derr;
        int    c, guard;
        obs_t  o, e;
        ap_v = 1'b0; dp_v = 1'b0; c = 0; guard = 0;
        ap = '0; dp = '0;
        obs_q.delete(); exp_q.delete(); rd_q.delete();
        while ((seq_q.size() > 0 || ap_v || dp_v) && guard < 400) begin
            @(negedge hclk);
            guard++;
            o.rdy = hready_c; o.rsp = hresp_c; o.rd = hrdata_c;
            if (dp_v) begin
                derr = is_err(dp);
                if (derr) begin
                    e.rdy = (c == 1); e.rsp = 1'b1; e.rd = 32'h0;
                end else begin
                    e.rdy = (c == ws_of[cur]); e.rsp = 1'b0;
                    e.rd  = (e.rdy && !dp.wr) ? mem_m[cur][widx(dp.addr)] : 32'h0;
                    if (e.rdy && !dp.wr) rd_q.push_back(o.rd);
                    if (e.rdy && dp.wr)  model_write(dp);
                end
            end else begin
                e.rdy = 1'b1; e.rsp = 1'b0; e.rd = 32'h0;
            end
            obs_q.push_back(o);
            exp_q.push_back(e);
            if (!ap_v && seq_q.size() > 0) begin
                ap   = seq_q.pop_front();
                ap_v = 1'b1;
            end
            hsel_b   = ap_v ? ap.sel : 1'b0;
            htrans_b = ap_v ? ap.trans : 2'b00;
            hwrite_b = ap.wr;
            hsize_b  = ap.size;
            haddr_b  = ap.addr;
            hwdata_b = dp_v ? dp.data : 32'h0;
            if (e.rdy) begin
                dp_v = 1'b0;
                if (ap_v) begin
                    if (ap.sel && ap.trans[1]) begin
                        dp = ap; dp_v = 1'b1; c = 0;
                    end
                    ap_v = 1'b0;
                end
            end else begin
                c++;
            end
        end
        if (guard >= 400) begin
            miscompares++;
            $display("FAIL seq_timeout: %0d transfers left after %0d cycles, want 0", seq_q.size(), guard);
            seq_q.delete();
        end
        @(negedge hclk);
        drive_idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int k = 0; k < NDUT; k++) begin
            vectors++;
            if (hready_o[k] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_hready dut%0d: got %b want 1", k, hready_o[k]);
            end
            vectors++;
            if (hresp_o[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hresp dut%0d: got %b want 0", k, hresp_o[k]);
            end
            vectors++;
            if (hrdata_o[k] !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_hrdata dut%0d: got %08h want 00000000", k, hrdata_o[k]);
            end
        end
    endtask

    task automatic test_fill();
        for (int k = 0; k < NDUT; k++) begin
            cur = k;
            for (int w = 0; w < DEPTH; w++)
                seq_q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'(w * 4), $urandom()));
            run_seq();
            foreach (obs_q[i]) begin
                vectors++;
                if (obs_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL fill dut%0d cyc%0d: got rdy=%b resp=%b rd=%08h want rdy=%b resp=%b rd=%08h",
                             k, i, obs_q[i].rdy, obs_q[i].rsp, obs_q[i].rd, exp_q[i].rdy, exp_q[i].rsp, exp_q[i].rd);
                end
            end
        end
    endtask

    task automatic test_word_rw();
        cur = 0;
        seq_q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h0, 32'h0000_1111));
        seq_q.push_back(mk(1'b1, 2'b11, 1'b1, 3'd2, 32'h4, 32'h0000_2222));
        seq_q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h0, 32'h0));
        seq_q.push_back(mk(1'b1, 2'b11, 1'b0, 3'd2, 32'h4, 32'h0));
        run_seq();
        foreach (obs_q[i]) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL word_rw cyc%0d: got rdy=%b resp=%b rd=%08h want rdy=%b resp=%b rd=%08h",
                         i, obs_q[i].rdy, obs_q[i].rsp, obs_q[i].rd, exp_q[i].rdy, exp_q[i].rsp, exp_q[i].rd);
            end
        end
        vectors++;
        if (rd_q.size() != 2 || rd_q[0] !== 32'h0000_1111 || rd_q[1] !== 32'h0000_2222) begin
            miscompares++;
            $display("FAIL word_rw_data: got %0d reads first=%08h want 2 reads 00001111,00002222",
                     rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 32'h0);
        end
    endtask

    task automatic test_lanes();
        cur = 0;
        seq_q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h8, 32'hAABB_CCDD));
        seq_q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd0, 32'h9, 32'h0000_EE00));
        seq_q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd1, 32'hA, 32'h1234_0000));
        seq_q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h8, 32'h0));
        run_seq();
        foreach (obs_q[i]) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL lanes cyc%0d: got rdy=%b resp=%b rd=%08h want rdy=%b resp=%b rd=%08h",
                         i, obs_q[i].rdy, obs_q[i].rsp, obs_q[i].rd, exp_q[i].rdy, exp_q[i].rsp, exp_q[i].rd);
            end
        end
        vectors++;
        if (rd_q.size() != 1 || rd_q[0] !== 32'h1234_EEDD) begin
            miscompares++;
            $display("FAIL lanes_data: got %0d reads %08h want 1234eedd",
                     rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 32'h0);
        end
    endtask

    task automatic test_error();
        cur = 0;
        seq_q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h6, 32'hDEAD_BEEF));
        seq_q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h4, 32'h0));
        seq_q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd4, 32'h0, 32'hDEAD_BEEF));
        seq_q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd1, 32'h3, 32'hDEAD_BEEF));
        seq_q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h0, 32'h0));
        run_seq();
        foreach (obs_q[i]) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL error cyc%0d: got rdy=%b resp=%b rd=%08h want rdy=%b resp=%b rd=%08h",
                         i, obs_q[i].rdy, obs_q[i].rsp, obs_q[i].rd, exp_q[i].rdy, exp_q[i].rsp, exp_q[i].rd);
            end
        end
        vectors++;
        if (rd_q.size() != 2 || rd_q[0] !== 32'h0000_2222 || rd_q[1] !== 32'h0000_1111) begin
            miscompares++;
            $display("FAIL error_nowrite: got %0d reads first=%08h want 2 reads 00002222,00001111",
                     rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 32'h0);
        end
    endtask

    task automatic test_idle_alias();
        cur = 0;
        seq_q.push_back(mk(1'b1, 2'b00, 1'b1, 3'd2, 32'h0, 32'hBAD0_0001));
        seq_q.push_back(mk(1'b0, 2'b10, 1'b1, 3'd2, 32'h0, 32'hBAD0_0002));
        seq_q.push_back(mk(1'b1, 2'b01, 1'b1, 3'd2, 32'h0, 32'hBAD0_0003));
        seq_q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h0, 32'h0));
        seq_q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'(DEPTH * 4), 32'hA11A_5EDD));
        seq_q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h0, 32'h0));
        run_seq();
        foreach (obs_q[i]) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL idle_alias cyc%0d: got rdy=%b resp=%b rd=%08h want rdy=%b resp=%b rd=%08h",
                         i, obs_q[i].rdy, obs_q[i].rsp, obs_q[i].rd, exp_q[i].rdy, exp_q[i].rsp, exp_q[i].rd);
            end
        end
        vectors++;
        if (rd_q.size() != 2 || rd_q[0] !== 32'h0000_1111 || rd_q[1] !== 32'hA11A_5EDD) begin
            miscompares++;
            $display("FAIL idle_alias_data: got %0d reads first=%08h want 2 reads 00001111,a11a5edd",
                     rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 32'h0);
        end
    endtask

    task automatic test_wait_states();
        int lows;
        cur = 1;
        seq_q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'hF0F0_F0F0));
        seq_q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0));
        run_seq();
        lows = 0;
        foreach (obs_q[i]) begin
            if (obs_q[i].rdy === 1'b0) lows++;
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL wait cyc%0d: got rdy=%b resp=%b rd=%08h want rdy=%b resp=%b rd=%08h",
                         i, obs_q[i].rdy, obs_q[i].rsp, obs_q[i].rd, exp_q[i].rdy, exp_q[i].rsp, exp_q[i].rd);
            end
        end
        vectors++;
        if (lows != 4) begin
            miscompares++;
            $display("FAIL wait_count: got %0d hready-low cycles want 4", lows);
        end
        vectors++;
        if (rd_q.size() != 1 || rd_q[0] !== 32'hF0F0_F0F0) begin
            miscompares++;
            $display("FAIL wait_data: got %0d reads %08h want f0f0f0f0",
                     rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 32'h0);
        end
    endtask

    task automatic test_reset_mid_wait();
        cur = 2;
        seq_q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h0, 32'h0BAD_F00D));
        run_seq();
        foreach (obs_q[i]) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL rst_pre cyc%0d: got rdy=%b resp=%b rd=%08h want rdy=%b resp=%b rd=%08h",
                         i, obs_q[i].rdy, obs_q[i].rsp, obs_q[i].rd, exp_q[i].rdy, exp_q[i].rsp, exp_q[i].rd);
            end
        end
        hsel_b = 1'b1; htrans_b = 2'b10; hwrite_b = 1'b1; hsize_b = 3'd2; haddr_b = 32'h0;
        @(negedge hclk);
        hsel_b = 1'b0; htrans_b = 2'b00; hwdata_b = 32'h5555_5555;
        vectors++;
        if (hready_c !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_wait1: got hready=%b want 0", hready_c);
        end
        @(negedge hclk);
        vectors++;
        if (hready_c !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_wait2: got hready=%b want 0", hready_c);
        end
        hreset = 1'b1;
        @(negedge hclk);
        hreset = 1'b0;
        vectors++;
        if (hready_c !== 1'b1 || hresp_c !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_after: got hready=%b hresp=%b want 1 0", hready_c, hresp_c);
        end
        drive_idle();
        seq_q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h0, 32'h0));
        run_seq();
        vectors++;
        if (rd_q.size() != 1 || rd_q[0] !== 32'h0BAD_F00D) begin
            miscompares++;
            $display("FAIL rst_dropped: got %0d reads %08h want 0badf00d",
                     rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            cur = k;
            seq_q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h30, 32'h0123_4567));
            seq_q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h30, 32'h0));
            seq_q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd0, 32'h31, 32'h0000_AB00));
            seq_q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h30, 32'h0));
            run_seq();
            foreach (obs_q[i]) begin
                vectors++;
                if (obs_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL b2b dut%0d cyc%0d: got rdy=%b resp=%b rd=%08h want rdy=%b resp=%b rd=%08h",
                             k, i, obs_q[i].rdy, obs_q[i].rsp, obs_q[i].rd, exp_q[i].rdy, exp_q[i].rsp, exp_q[i].rd);
                end
            end
            vectors++;
            if (rd_q.size() != 2 || rd_q[0] !== 32'h0123_4567 || rd_q[1] !== 32'h0123_AB67) begin
                miscompares++;
                $display("FAIL b2b_raw dut%0d: got %0d reads first=%08h want 01234567,0123ab67",
                         k, rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 32'h0);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  sz;
        logic [31:0] a;
        logic [1:0]  tr;
        int          r;
        for (int k = 0; k < NDUT; k++) begin
            cur = k;
            for (int n = 0; n < 50; n++) begin
                r  = int'($urandom_range(0, 9));
                sz = (r <= 2) ? 3'(r) : ((r <= 7) ? 3'd2 : 3'($urandom_range(3, 7)));
                a  = 32'($urandom_range(0, 511));
                if (sz <= 3'd2 && $urandom_range(0, 3) != 0)
                    a = a - (a % (32'd1 << sz));
                tr = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
                seq_q.push_back(mk($urandom_range(0, 9) != 0, tr, 1'($urandom_range(0, 1)), sz, a, $urandom()));
            end
            run_seq();
            foreach (obs_q[i]) begin
                vectors++;
                if (obs_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL random dut%0d cyc%0d: got rdy=%b resp=%b rd=%08h want rdy=%b resp=%b rd=%08h",
                             k, i, obs_q[i].rdy, obs_q[i].rsp, obs_q[i].rd, exp_q[i].rdy, exp_q[i].rsp, exp_q[i].rd);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NDUT; k++)
            for (int w = 0; w < DEPTH; w++)
                mem_m[k][w] = 32'h0;
        drive_idle();
        hreset = 1'b1;
        repeat (3) @(negedge hclk);
        hreset = 1'b0;
        @(negedge hclk);
        test_reset();
        test_fill();
        test_word_rw();
        test_lanes();
        test_error();
        test_idle_alias();
        test_wait_states();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
